riscv_encode: RTL and testbench
===============================

Name: riscv_encode

Overview:
Sequential RISC-V RV32I instruction encoder, the inverse of the field decoder. It accepts field values plus a format selector and assembles a 32-bit instruction word. The immediate is range- and alignment-checked, and the result is registered behind a valid/ready handshake. It feeds instruction memory loaders, self-test generators and decode loopback benches. It also keeps encoded and error statistics counters.

Parameters:
CNT_W, 16, width of the wrapping encoded-instruction counter
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request carries valid fields
in_ready  output  1  encoder can accept a request this cycle
fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
opcode  input  7  major opcode, placed at [6:0]
rd  input  5  destination register
funct3  input  3  minor opcode
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  R-type upper function field
imm  input  32  signed immediate, or byte offset for B/J, or full upper value for U
out_valid  output  1  out_instr/out_err valid
out_ready  input  1  consumer accepts output
out_instr  output  32  encoded instruction word
out_err  output  1  request was illegal; out_instr forced to NOP
enc_count  output  CNT_W  accepted requests, wraps modulo 2^CNT_W
err_count  output  ERR_W  errored requests, saturates at all-ones

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - A request is accepted when in_valid && in_ready.
  - On accept, the output register loads next cycle with out_valid=1. Latency is 1 cycle.
  - Output is held stable while out_valid && !out_ready.
  - out_valid clears when out_ready=1 and no new accept occurs in the same cycle.
  - Simultaneous drain and accept loads the new word with no bubble, giving full throughput.
- Encoding (opcode always in [6:0]; fields unused by a format are ignored):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Error conditions (any one sets the error):
  - fmt is 6 or 7.
  - opcode[1:0] != 2'b11.
  - I/S with imm outside [-2048, 2047].
  - B with imm outside [-4096, 4094], or imm[0]=1.
  - J with imm outside [-1048576, 1048574], or imm[0]=1.
  - U with imm[11:0] != 0.
- On error: out_instr = 32'h00000013 (ADDI x0,x0,0) and out_err=1. Otherwise out_err=0.
- Counters:
  - enc_count increments on every accept, including errored ones, and wraps.
  - err_count increments on an accepted errored request and holds at max.
  - Both counters update in the same cycle the output register loads.
- Reset mid-transfer: the pending output is discarded (out_valid=0) and counters are cleared. No partial state survives.
- in_valid while in_ready=0: no effect. The source must hold its request.

Test Plan:
- R ADD x1,x2,x3 (fmt0, op 0x33, f3 0, f7 0) -> one cycle later out_valid=1, out_instr=0x003100B3, out_err=0, enc_count=1.
- I ADDI x1,x2,100 -> 0x06410093; S SW x3,8(x2) (f3 010, op 0x23) -> 0x00312423; back-to-back accepts with out_ready=1 show no bubbles.
- B BEQ x1,x2,+16 (op 0x63) -> 0x00208863; B with imm=3 -> out_instr=0x00000013, out_err=1, err_count increments.
- U LUI x1, imm=0x12345000 (op 0x37) -> 0x123450B7; J JAL x1,+2048 (op 0x6F) -> 0x001000EF; U with imm=0x12345001 -> err.
- Backpressure: hold out_ready=0 for 3 cycles after an accept -> in_ready=0, out_instr stable, second request held. Raising out_ready drains and accepts in the same cycle.
- Drive 300 errored requests -> err_count saturates at 0xFF. Assert rst with out_valid=1 -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/riscv_encode.sv
// RV32I instruction encoder: assembles a 32-bit word from fields and a format selector.
// Illegal requests become ADDI x0,x0,0 with out_err set. Output is registered behind a valid/ready pair.
module riscv_encode #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [2:0]  FMT_R    = 3'd0;
    localparam logic [2:0]  FMT_I    = 3'd1;
    localparam logic [2:0]  FMT_S    = 3'd2;
    localparam logic [2:0]  FMT_B    = 3'd3;
    localparam logic [2:0]  FMT_U    = 3'd4;
    localparam logic [2:0]  FMT_J    = 3'd5;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic               accept;
    logic signed [31:0] imm_s;
    logic               imm12_ok, immb_ok, immj_ok, immu_ok;
    logic [31:0]        enc_word;
    logic               fmt_err;
    logic               enc_err;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Branch/jump offsets must be even; the upper bounds are the largest even values.
    assign imm_s    = imm;
    assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign immb_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
    assign immj_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
    assign immu_ok  = (imm[11:0] == 12'd0);

    always_comb begin
        enc_word = NOP_WORD;
        fmt_err  = 1'b0;
        case (fmt)
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                fmt_err  = !imm12_ok;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                fmt_err  = !imm12_ok;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                fmt_err  = !immb_ok;
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, opcode};
                fmt_err  = !immu_ok;
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                fmt_err  = !immj_ok;
            end
            default: fmt_err = 1'b1;
        endcase
        enc_err = fmt_err || (opcode[1:0] != 2'b11);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_err ? NOP_WORD : enc_word;
            out_err_d   = enc_err;
            enc_count_d = enc_count_q + CNT_W'(1);
            if (enc_err && (err_count_q != {ERR_W{1'b1}})) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_err_q   <= 1'b0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_riscv_encode.sv
// Self-checking bench for riscv_encode: directed vectors, backpressure, saturation,
// async reset and randomized traffic compared each cycle against an arithmetic model.
module tb_riscv_encode;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    riscv_encode #(.CNT_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .funct7(funct7), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Field placement done by shifting into bit positions, legality by integer ranges.
    function automatic logic [32:0] model_encode(
        input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_i,
        input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
        input logic [6:0] f7, input logic [31:0] im);
        int          v;
        logic [31:0] base, w;
        logic        bad;
        v    = $signed(im);
        base = 32'(op) | (32'(rd_i) << 7) | (32'(f3) << 12) | (32'(r1) << 15);
        bad  = (32'(op) & 32'h3) != 32'h3;
        w    = 32'd0;
        case (f)
            3'd0: w = base | (32'(r2) << 20) | (32'(f7) << 25);
            3'd1: begin
                w = base | ((im & 32'hFFF) << 20);
                if (v < -2048 || v > 2047) bad = 1'b1;
            end
            3'd2: begin
                w = 32'(op) | (32'(f3) << 12) | (32'(r1) << 15) | (32'(r2) << 20)
                    | ((im & 32'h1F) << 7) | (((im >> 5) & 32'h7F) << 25);
                if (v < -2048 || v > 2047) bad = 1'b1;
            end
            3'd3: begin
                w = 32'(op) | (32'(f3) << 12) | (32'(r1) << 15) | (32'(r2) << 20)
                    | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
                if (v < -4096 || v > 4094 || (v % 2) != 0) bad = 1'b1;
            end
            3'd4: begin
                w = (im & 32'hFFFFF000) | 32'(op) | (32'(rd_i) << 7);
                if ((im & 32'hFFF) != 0) bad = 1'b1;
            end
            3'd5: begin
                w = 32'(op) | (32'(rd_i) << 7) | (((im >> 12) & 32'hFF) << 12)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 20) & 32'h1) << 31);
                if (v < -1048576 || v > 1048574 || (v % 2) != 0) bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = 32'h0000_0013;
        return {bad, w};
    endfunction

    // Transaction-level model of the output register and statistics.
    logic        exp_valid = 1'b0;
    logic [31:0] exp_instr = 32'd0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_enc = 16'd0;
    logic [7:0]  exp_errc = 8'd0;

    always @(posedge clk or posedge rst) begin
        logic [32:0] m;
        if (rst) begin
            exp_valid <= 1'b0;
            exp_instr <= 32'd0;
            exp_err   <= 1'b0;
            exp_enc   <= 16'd0;
            exp_errc  <= 8'd0;
        end else if (in_valid && (!exp_valid || out_ready)) begin
            m = model_encode(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm);
            exp_valid <= 1'b1;
            exp_instr <= m[31:0];
            exp_err   <= m[32];
            exp_enc   <= exp_enc + 16'd1;
            if (m[32] && exp_errc < 8'd255) exp_errc <= exp_errc + 8'd1;
        end else if (out_ready) begin
            exp_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("out_instr", out_instr, exp_instr);
                check("out_err", 32'(out_err), 32'(exp_err));
            end
            check("enc_count", 32'(enc_count), 32'(exp_enc));
            check("err_count", 32'(err_count), 32'(exp_errc));
        end
    end

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_i,
                           input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = rd_i; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7; imm = im;
    endtask

    // Entered at posedge+1; leaves in_valid high so consecutive calls are back-to-back.
    task automatic directed(input string name, input logic [2:0] f, input logic [6:0] op,
                            input logic [4:0] rd_i, input logic [2:0] f3, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [6:0] f7, input logic [31:0] im,
                            input logic [31:0] exp_w, input logic exp_e);
        logic [32:0] m;
        m = model_encode(f, op, rd_i, f3, r1, r2, f7, im);
        check({name, "_model"}, m[31:0], exp_w);
        check({name, "_model_err"}, 32'(m[32]), 32'(exp_e));
        set_req(f, op, rd_i, f3, r1, r2, f7, im);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_instr"}, out_instr, exp_w);
        check({name, "_err"}, 32'(out_err), 32'(exp_e));
    endtask

    int bnd [18] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097, 4096,
                     -1048576, 1048574, 1048576, -1048578, 0, 1, -1, 16, 'h12345000};

    initial begin
        logic [31:0] tmp;
        logic [7:0]  errc_before;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        directed("add", 3'd0, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'd0, 32'h003100B3, 1'b0);
        check("add_enc_count", 32'(enc_count), 32'd1);
        directed("addi", 3'd1, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'd100, 32'h06410093, 1'b0);
        directed("sw", 3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd3, 7'd0, 32'd8, 32'h00312423, 1'b0);
        directed("beq", 3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd16, 32'h00208863, 1'b0);
        errc_before = err_count;
        directed("beq_odd", 3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 32'h00000013, 1'b1);
        check("beq_odd_errcnt", 32'(err_count), 32'(errc_before) + 32'd1);
        directed("lui", 3'd4, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 32'h123450B7, 1'b0);
        directed("jal", 3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0);
        directed("lui_bad", 3'd4, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345001, 32'h00000013, 1'b1);
        directed("i_max", 3'd1, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2047, 32'h7FF00013, 1'b0);
        directed("i_over", 3'd1, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h00000013, 1'b1);
        directed("bad_op", 3'd0, 7'h32, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'd0, 32'h00000013, 1'b1);
        directed("fmt6", 3'd6, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'd0, 32'h00000013, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure: ADD parked in the output, ADDI waits until the drain cycle.
        directed("bp_a", 3'd0, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'd0, 32'h003100B3, 1'b0);
        out_ready = 1'b0;
        set_req(3'd1, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'd100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", out_instr, 32'h003100B3);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drain_valid", 32'(out_valid), 32'd1);
        check("bp_drain_instr", out_instr, 32'h06410093);
        in_valid = 1'b0;

        // Saturate the error counter.
        set_req(3'd7, 7'h33, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("err_saturate", 32'(err_count), 32'hFF);

        // Asynchronous reset while an output is pending.
        directed("pre_rst", 3'd0, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'd0, 32'h003100B3, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_instr", out_instr, 32'd0);
        check("arst_err", 32'(out_err), 32'd0);
        check("arst_enc", 32'(enc_count), 32'd0);
        check("arst_errc", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic, immediates biased towards range edges.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tmp       = $urandom();
            fmt       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            opcode    = ($urandom_range(0, 7) == 0) ? tmp[6:0] : {tmp[6:2], 2'b11};
            rd        = tmp[11:7];
            funct3    = tmp[14:12];
            rs1       = tmp[19:15];
            rs2       = tmp[24:20];
            funct7    = tmp[31:25];
            case ($urandom_range(0, 3))
                0: imm = $urandom();
                1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2: imm = 32'(bnd[$urandom_range(0, 17)]);
                default: imm = $urandom() & 32'hFFFFF000;
            endcase
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
